upc_tag_transmitter: RTL and testbench
======================================

# upc_tag_transmitter

Serial tag transmitter: the sending end of the product-tag link read by the store's electronic detector device. On a start request it latches a 3-bit product code (U, P, C) and the mark bit M. It then shifts them out as one framed, parity-protected serial word on a single line, at a parameterised bit period. It lets the bench or board drive a detector-side reader with realistic serial tags instead of static switch values.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clock cycles each serial bit is held; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to send one frame; sampled only in IDLE.
- upc  input  3  product code, upc[2]=U, upc[1]=P, upc[0]=C; latched when a start is accepted.
- mark  input  1  mark bit M; latched together with upc.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line.
- done  output  1  one-cycle pulse when a frame completes.
- frame_cnt  output  8  number of frames completed since reset, modulo 256.

## Operation
- All outputs are registered.
- FSM states and transitions:
  - IDLE -> START on start=1.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY after 4 bits.
  - PARITY -> STOP.
  - STOP -> IDLE.
- Frame is 7 bits, in order:
  - start bit 0
  - U, P, C, M
  - even parity bit, chosen so that U^P^C^M^parity = 0
  - stop bit 1
- Accept: start=1 while in IDLE. upc and mark are copied into a 4-bit shift register on the same edge. Later changes on upc, mark or start do not affect the frame in progress.
- start while busy=1 is ignored. It is not queued and not counted.
- Internal counters:
  - bit-period counter, width ceil(log2(CLKS_PER_BIT)), minimum 1. Counts 0..CLKS_PER_BIT-1, then wraps and advances to the next bit.
  - 2-bit data index.
- frame_cnt increments on the edge that raises done. It wraps 255 -> 0.
- Reset values (asynchronous, take effect immediately even mid-frame): state=IDLE, tx=1, busy=0, done=0, frame_cnt=0, all counters and the shift register 0. An aborted frame is not counted and produces no done.

## Timing
- Let N = CLKS_PER_BIT, and let edge k be the edge at which start is accepted.
- After edge k: tx=0 (start bit) and busy=1.
- Data bit i (i=0..3, U first) is on tx after edges k+N(1+i) through k+N(2+i)-1.
- Parity is on tx after edge k+5N. Stop bit is on tx after edge k+6N.
- After edge k+7N:
  - state=IDLE, tx=1, busy=0.
  - done=1 for exactly one cycle.
  - frame_cnt updated.
- busy is therefore high for exactly 7N cycles. Latency from accept to first tx change is 1 cycle.
- start=1 held continuously gives back-to-back frames separated by exactly one idle cycle with tx=1. That cycle is the done cycle, and the next start is accepted at its end.
- With N=1 every state lasts one cycle, and DATA lasts 4 cycles.
- reset asserted for any duration, at any point, forces the reset values immediately. The first start after reset deasserts is accepted at the next edge that sees start=1.

## Test plan
- Reset check: assert reset for 3 cycles.
  - During reset: tx=1, busy=0, done=0, frame_cnt=0.
  - After release, with start=0 for 10 cycles: outputs unchanged.
- Single frame, N=4, upc=3'b110, mark=0, one-cycle start pulse:
  - tx sequence in 4-cycle groups is 0,1,1,0,0,0,1 (parity 0).
  - busy high 28 cycles; done pulses once; frame_cnt=1.
- Odd-weight frame, N=4, upc=3'b101, mark=1:
  - tx groups are 0,1,0,1,1,1,1 (parity 1).
  - Change upc to 3'b000 mid-frame: tx sequence unchanged.
- Start ignored while busy: pulse start again at cycles 5 and 20 of a frame.
  - Only one frame is sent; frame_cnt increments by 1.
  - Next frame starts only after a new start in IDLE.
- Back-to-back and wrap: hold start=1 with N=1 for 260 frames.
  - Each frame is 7 cycles followed by 1 idle cycle with tx=1 and done=1.
  - frame_cnt goes 255 -> 0 -> 4 at the end.
- Reset mid-frame: assert reset during the DATA state of a frame.
  - Immediately: tx=1, busy=0, frame_cnt=0.
  - No done pulse.
  - A subsequent frame is sent correctly.

Source files
------------

// File: rtl/upc_tag_transmitter.sv
// upc_tag_transmitter: serial sender for the product-tag link.
// Ports: clk/reset (async high); start, upc[2:0]={U,P,C}, mark in;
//        tx (idles high), busy, done pulse, frame_cnt[7:0] out.
module upc_tag_transmitter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] upc,
    input  logic       mark,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt
);

    // Bit-period counter is at least one bit wide so N=1 still works.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic [1:0]      r_idx,   w_idx_nxt;
    logic [3:0]      r_sr,    w_sr_nxt;
    logic            r_par,   w_par_nxt;
    logic            r_tx,    w_tx_nxt;
    logic            r_busy,  w_busy_nxt;
    logic            r_done,  w_done_nxt;
    logic [7:0]      r_fcnt,  w_fcnt_nxt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sr    <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sr    <= w_sr_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Next-state and next-output logic. Each output is computed one
    // edge ahead so the line changes exactly on the bit boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_sr_nxt    = r_sr;
        w_par_nxt   = r_par;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_fcnt_nxt  = r_fcnt;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = 1'b1;
                if (start) begin
                    w_state_nxt = S_START;
                    w_sr_nxt    = {upc, mark};
                    w_par_nxt   = ^{upc, mark};
                    w_idx_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_sr[3];
                    w_sr_nxt    = {r_sr[2:0], 1'b0};
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_par;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                        w_tx_nxt  = r_sr[3];
                        w_sr_nxt  = {r_sr[2:0], 1'b0};
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_PARITY: begin
                if (w_wrap) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_wrap) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_fcnt_nxt  = r_fcnt + 8'd1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_cnt = r_fcnt;

endmodule

// File: tb/tb_upc_tag_transmitter.sv
// tb_upc_tag_transmitter: directed bench for the tag transmitter.
// Instance a runs at 4 clocks/bit, instance b at 1 clock/bit.
module tb_upc_tag_transmitter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [2:0] upc_a = '0, upc_b = '0;
    logic       mark_a = 1'b0, mark_b = 1'b0;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;
    logic [7:0] fc_a, fc_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    upc_tag_transmitter #(.CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .upc(upc_a),
        .mark(mark_a), .tx(tx_a), .busy(busy_a), .done(done_a),
        .frame_cnt(fc_a)
    );

    upc_tag_transmitter #(.CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .upc(upc_b),
        .mark(mark_b), .tx(tx_b), .busy(busy_b), .done(done_b),
        .frame_cnt(fc_b)
    );

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 ||
                fc_a !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold: tx=%b busy=%b done=%b fc=%0d want 1 0 0 0",
                         tx_a, busy_a, done_a, fc_a);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 ||
                fc_a !== 8'd0 || tx_b !== 1'b1 || busy_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: tx=%b busy=%b done=%b fc=%0d want 1 0 0 0",
                         tx_a, busy_a, done_a, fc_a);
            end
        end
    endtask

    // Frame 0,1,1,0,0,0,1 (U=1 P=1 C=0 M=0, parity 0).
    task automatic test_single();
        logic [6:0] exp;
        exp = 7'b0110001;
        upc_a = 3'b110; mark_a = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int s = 0; s < 28; s++) begin
            checks++;
            if (tx_a !== exp[6 - s / 4] || busy_a !== 1'b1 || done_a !== 1'b0) begin
                errors++;
                $display("FAIL single_bit%0d: tx=%b busy=%b done=%b want %b 1 0",
                         s, tx_a, busy_a, done_a, exp[6 - s / 4]);
            end
            @(negedge clk);
        end
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b1 || fc_a !== 8'd1) begin
            errors++;
            $display("FAIL single_end: tx=%b busy=%b done=%b fc=%0d want 1 0 1 1",
                     tx_a, busy_a, done_a, fc_a);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || fc_a !== 8'd1) begin
            errors++;
            $display("FAIL single_done_pulse: done=%b fc=%0d want 0 1", done_a, fc_a);
        end
    endtask

    // Frame 0,1,0,1,1,1,1 (U=1 P=0 C=1 M=1, parity 1); inputs change mid-frame.
    task automatic test_odd_weight();
        logic [6:0] exp;
        exp = 7'b0101111;
        upc_a = 3'b101; mark_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int s = 0; s < 28; s++) begin
            if (s == 10) begin
                upc_a = 3'b000; mark_a = 1'b0;
            end
            checks++;
            if (tx_a !== exp[6 - s / 4] || busy_a !== 1'b1) begin
                errors++;
                $display("FAIL odd_bit%0d: tx=%b busy=%b want %b 1",
                         s, tx_a, busy_a, exp[6 - s / 4]);
            end
            @(negedge clk);
        end
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || fc_a !== 8'd2) begin
            errors++;
            $display("FAIL odd_end: done=%b busy=%b fc=%0d want 1 0 2",
                     done_a, busy_a, fc_a);
        end
    endtask

    // Frame 0,0,1,1,1,1,1 (U=0 P=1 C=1 M=1, parity 1); start pulses while busy.
    task automatic test_ignore_busy();
        logic [6:0] exp;
        exp = 7'b0011111;
        @(negedge clk);
        upc_a = 3'b011; mark_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int s = 0; s < 28; s++) begin
            start_a = (s == 5 || s == 20);
            checks++;
            if (tx_a !== exp[6 - s / 4] || busy_a !== 1'b1) begin
                errors++;
                $display("FAIL ignore_bit%0d: tx=%b busy=%b want %b 1",
                         s, tx_a, busy_a, exp[6 - s / 4]);
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        checks++;
        if (done_a !== 1'b1 || fc_a !== 8'd3) begin
            errors++;
            $display("FAIL ignore_end: done=%b fc=%0d want 1 3", done_a, fc_a);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (busy_a !== 1'b0 || tx_a !== 1'b1 || fc_a !== 8'd3) begin
                errors++;
                $display("FAIL ignore_no_requeue: busy=%b tx=%b fc=%0d want 0 1 3",
                         busy_a, tx_a, fc_a);
            end
        end
        upc_a = 3'b000; mark_a = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || tx_a !== 1'b0) begin
            errors++;
            $display("FAIL ignore_restart: busy=%b tx=%b want 1 0", busy_a, tx_a);
        end
        repeat (28) @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || fc_a !== 8'd4) begin
            errors++;
            $display("FAIL ignore_second: done=%b fc=%0d want 1 4", done_a, fc_a);
        end
    endtask

    // N=1, start held: 7-cycle frame 0,1,0,0,0,1,1 then one done/idle cycle.
    task automatic test_back_to_back();
        logic [6:0] exp;
        logic [6:0] got;
        logic [7:0] want_fc;
        logic       all_busy;
        exp = 7'b0100011;
        upc_b = 3'b100; mark_b = 1'b0; start_b = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 260; f++) begin
            all_busy = 1'b1;
            for (int c = 0; c < 7; c++) begin
                got[6 - c] = tx_b;
                if (busy_b !== 1'b1 || done_b !== 1'b0) all_busy = 1'b0;
                @(negedge clk);
            end
            checks++;
            if (got !== exp || all_busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_frame%0d: tx=%b busy_ok=%b want %b 1",
                         f, got, all_busy, exp);
            end
            want_fc = 8'(f + 1);
            if (f == 259) start_b = 1'b0;
            checks++;
            if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b1 ||
                fc_b !== want_fc) begin
                errors++;
                $display("FAIL b2b_gap%0d: tx=%b busy=%b done=%b fc=%0d want 1 0 1 %0d",
                         f, tx_b, busy_b, done_b, fc_b, want_fc);
            end
            @(negedge clk);
        end
        checks++;
        if (busy_b !== 1'b0 || done_b !== 1'b0 || fc_b !== 8'd4) begin
            errors++;
            $display("FAIL b2b_final: busy=%b done=%b fc=%0d want 0 0 4",
                     busy_b, done_b, fc_b);
        end
    endtask

    task automatic test_reset_midframe();
        logic [6:0] exp;
        logic       saw_done;
        upc_a = 3'b111; mark_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || tx_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: busy=%b tx=%b want 1 1", busy_a, tx_a);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || fc_a !== 8'd0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: tx=%b busy=%b fc=%0d done=%b want 1 0 0 0",
                     tx_a, busy_a, fc_a, done_a);
        end
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0 || fc_a !== 8'd0) begin
            errors++;
            $display("FAIL mid_no_done: activity=%b fc=%0d want 0 0", saw_done, fc_a);
        end
        // Frame 0,0,1,0,1,0,1 (U=0 P=1 C=0 M=1, parity 0).
        exp = 7'b0010101;
        upc_a = 3'b010; mark_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int s = 0; s < 28; s++) begin
            checks++;
            if (tx_a !== exp[6 - s / 4] || busy_a !== 1'b1) begin
                errors++;
                $display("FAIL mid_after_bit%0d: tx=%b busy=%b want %b 1",
                         s, tx_a, busy_a, exp[6 - s / 4]);
            end
            @(negedge clk);
        end
        checks++;
        if (done_a !== 1'b1 || fc_a !== 8'd1) begin
            errors++;
            $display("FAIL mid_after_end: done=%b fc=%0d want 1 1", done_a, fc_a);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_odd_weight();
        test_ignore_busy();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
